// File: rtl/reg_op_sequencer_pkg.sv
// Shared types for the register operand sequencer.
// Optional flags/CMP support is enabled by defining SEQ_FLAGS_EN.
package reg_op_sequencer_pkg;

  localparam int SEQ_DATA_W = 16;
  localparam int SEQ_ADDR_W = 3;

  localparam int OP_LSB = 12;
  localparam int RD_LSB = 9;
  localparam int RS_LSB = 6;
  localparam int RT_LSB = 3;
  localparam int IMM_W  = 9;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_MOV = 4'd5,
    OP_LDI = 4'd6,
    OP_CMP = 4'd7
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_EXEC,
    S_WB
  } state_e;

  // Undefined opcodes collapse to NOP; CMP only exists with flags.
  function automatic opcode_e decode_op(logic [3:0] raw);
    if (raw > 4'd7) return OP_NOP;
`ifndef SEQ_FLAGS_EN
    if (raw == 4'd7) return OP_NOP;
`endif
    return opcode_e'(raw);
  endfunction

  function automatic logic reads_a(opcode_e op);
    return op inside {OP_ADD, OP_SUB, OP_AND,
                      OP_OR, OP_MOV, OP_CMP};
  endfunction

  function automatic logic reads_b(opcode_e op);
    return op inside {OP_ADD, OP_SUB, OP_AND,
                      OP_OR, OP_CMP};
  endfunction

  function automatic logic writes_rf(opcode_e op);
    return op inside {OP_ADD, OP_SUB, OP_AND,
                      OP_OR, OP_MOV, OP_LDI};
  endfunction

  function automatic logic sets_flags(opcode_e op);
    return op inside {OP_ADD, OP_SUB, OP_CMP};
  endfunction

endpackage

// File: rtl/reg_op_sequencer_seq_alu.sv
// Combinational ALU for the operand sequencer.
// carry is carry-out for ADD and borrow for SUB/CMP.
module seq_alu
  import reg_op_sequencer_pkg::*;
#(
  parameter int DATA_W = SEQ_DATA_W
) (
  input  opcode_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  always_comb begin
    result = '0;
    carry  = 1'b0;
    unique case (op)
      OP_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
      OP_SUB,
      OP_CMP: begin
        result = a - b;
        carry  = (a < b);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_MOV: result = a;
      OP_LDI: result = b;
      default: ;
    endcase
  end

endmodule

// File: rtl/reg_op_sequencer.sv
// Multi-cycle operand sequencer in front of the 8x16 register bank.
// Define SEQ_FLAGS_EN to build the {C,N,Z} flags register and CMP.
module reg_op_sequencer
  import reg_op_sequencer_pkg::*;
#(
  parameter int DATA_W = SEQ_DATA_W,
  parameter int ADDR_W = SEQ_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [ADDR_W-1:0] rf_rsel,
  output logic [ADDR_W-1:0] rf_wsel,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy,
  output logic              done,
  output logic [2:0]        flags
);

  state_e            state_q;
  state_e            state_d;
  logic [15:0]       instr_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] r_q;
  logic [ADDR_W-1:0] rsel_q;
  opcode_e           op_in;
  opcode_e           op;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic [2:0]        instr_unused;

  assign op_in   = decode_op(instr[OP_LSB +: 4]);
  assign op      = decode_op(instr_q[OP_LSB +: 4]);
  assign imm_ext = {{(DATA_W-IMM_W){instr_q[IMM_W-1]}},
                    instr_q[IMM_W-1:0]};
  assign alu_b   = (op == OP_LDI) ? imm_ext : b_q;
  assign instr_unused = instr_q[2:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          unique case (1'b1)
            reads_a(op_in): state_d = S_RD_A;
            default:        state_d = S_EXEC;
          endcase
        end
      end
      S_RD_A: begin
        unique case (1'b1)
          reads_b(op): state_d = S_RD_B;
          default:     state_d = S_EXEC;
        endcase
      end
      S_RD_B: state_d = S_EXEC;
      S_EXEC: state_d = S_WB;
      S_WB:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    rf_we       = 1'b0;
    rf_rsel     = rsel_q;
    unique case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
      end
      S_RD_A: rf_rsel = instr_q[RS_LSB +: ADDR_W];
      S_RD_B: rf_rsel = instr_q[RT_LSB +: ADDR_W];
      S_WB: begin
        done  = 1'b1;
        rf_we = writes_rf(op);
      end
      default: ;
    endcase
  end

  assign rf_wsel  = instr_q[RD_LSB +: ADDR_W];
  assign rf_wdata = r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      rsel_q  <= '0;
    end else begin
      rsel_q <= rf_rsel;
      if (state_q == S_IDLE && instr_valid)
        instr_q <= instr;
      if (state_q == S_RD_A) a_q <= rf_rdata;
      if (state_q == S_RD_B) b_q <= rf_rdata;
      if (state_q == S_EXEC) r_q <= alu_result;
    end
  end

  seq_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (op),
    .a      (a_q),
    .b      (alu_b),
    .result (alu_result),
    .carry  (alu_carry)
  );

`ifdef SEQ_FLAGS_EN
  logic [2:0] flags_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else if (state_q == S_EXEC && sets_flags(op)) begin
      flags_q <= {alu_carry,
                  alu_result[DATA_W-1],
                  alu_result == '0};
    end
  end

  assign flags = flags_q;
`else
  logic alu_unused;

  assign alu_unused = alu_carry;
  assign flags      = 3'b000;
`endif

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Self-checking bench for reg_op_sequencer with a behavioural
// register-bank model and an instruction-level reference model.
module tb_reg_op_sequencer;

`ifdef SEQ_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic [15:0] rf_rdata;
  logic [2:0]  rf_rsel;
  logic [2:0]  rf_wsel;
  logic        rf_we;
  logic [15:0] rf_wdata;
  logic        instr_ready;
  logic        busy;
  logic        done;
  logic [2:0]  flags;

  int checks = 0;
  int errors = 0;

  logic [15:0] bank [8];
  logic [15:0] seed [8];
  logic        bank_load = 1'b0;
  logic [15:0] ref_rf [8];
  logic [2:0]  ref_flags = '0;
  logic [15:0] last_wdata;
  logic        last_we;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bank_load) begin
      for (int i = 0; i < 8; i++) bank[i] <= seed[i];
    end else if (rf_we) begin
      bank[rf_wsel] <= rf_wdata;
    end
  end

  assign rf_rdata = bank[rf_rsel];

  reg_op_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rf_rdata    (rf_rdata),
    .rf_rsel     (rf_rsel),
    .rf_wsel     (rf_wsel),
    .rf_we       (rf_we),
    .rf_wdata    (rf_wdata),
    .busy        (busy),
    .done        (done),
    .flags       (flags)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk(input int op, input int rd,
                                     input int rs, input int rt);
    return {op[3:0], rd[2:0], rs[2:0], rt[2:0], 3'b000};
  endfunction

  function automatic logic [15:0] ldi(input int rd,
                                      input logic [8:0] imm);
    return {4'd6, rd[2:0], imm};
  endfunction

  // Instruction-level reference: latency, write, result, flags.
  function automatic void model(input logic [15:0] ins,
                                input logic [2:0] fin,
                                output int lat,
                                output logic we,
                                output logic [15:0] res,
                                output logic [2:0] fout,
                                output bit ra,
                                output bit rb);
    int unsigned a, b, sum;
    a = ref_rf[ins[8:6]];
    b = ref_rf[ins[5:3]];
    lat = 2; we = 1'b0; res = '0; fout = fin;
    ra = 1'b0; rb = 1'b0;
    case (ins[15:12])
      4'd1: begin
        sum = a + b;
        res = sum[15:0];
        we = 1'b1; lat = 4; ra = 1'b1; rb = 1'b1;
        fout = FL ? {sum[16], res[15], res == 0} : 3'b000;
      end
      4'd2: begin
        res = 16'(a - b);
        we = 1'b1; lat = 4; ra = 1'b1; rb = 1'b1;
        fout = FL ? {a < b, res[15], res == 0} : 3'b000;
      end
      4'd3: begin
        res = 16'(a & b);
        we = 1'b1; lat = 4; ra = 1'b1; rb = 1'b1;
      end
      4'd4: begin
        res = 16'(a | b);
        we = 1'b1; lat = 4; ra = 1'b1; rb = 1'b1;
      end
      4'd5: begin
        res = 16'(a);
        we = 1'b1; lat = 3; ra = 1'b1;
      end
      4'd6: begin
        res = {{7{ins[8]}}, ins[8:0]};
        we = 1'b1;
      end
      4'd7: begin
        if (FL) begin
          res = 16'(a - b);
          lat = 4; ra = 1'b1; rb = 1'b1;
          fout = {a < b, res[15], res == 0};
        end
      end
      default: ;
    endcase
  endfunction

  // Call on a negedge with the DUT idle; returns on the next idle negedge.
  task automatic issue(input logic [15:0] ins);
    int lat;
    logic we;
    logic [15:0] res;
    logic [2:0] fnew;
    bit ra, rb;
    model(ins, ref_flags, lat, we, res, fnew, ra, rb);
    chk("ready_idle", instr_ready, 1);
    instr = ins;
    instr_valid = 1'b1;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c == 1) begin
        instr_valid = 1'b0;
        instr = 16'($urandom);
      end
      chk("busy", busy, 1);
      chk("ready_busy", instr_ready, 0);
      chk("done", done, c == lat);
      chk("we", rf_we, (c == lat) && we);
      if (c == 1 && ra) chk("rsel_a", rf_rsel, ins[8:6]);
      if (c == 2 && rb) chk("rsel_b", rf_rsel, ins[5:3]);
      if (c == lat) begin
        chk("flags_wb", flags, fnew);
        last_we = rf_we;
        last_wdata = rf_wdata;
        if (we) begin
          chk("wsel", rf_wsel, ins[11:9]);
          chk("wdata", rf_wdata, res);
        end
      end
    end
    @(negedge clk);
    if (we) ref_rf[ins[11:9]] = res;
    ref_flags = fnew;
    chk("busy_after", busy, 0);
    chk("done_after", done, 0);
  endtask

  initial begin
    logic [15:0] ins;
    int lat;
    logic we;
    logic [15:0] res;
    logic [2:0] fnew;
    bit ra, rb;

    for (int i = 0; i < 8; i++) begin
      seed[i] = 16'($urandom);
      ref_rf[i] = seed[i];
    end
    bank_load = 1'b1;
    #1;
    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_rsel", rf_rsel, 0);
    chk("rst_wsel", rf_wsel, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_flags", flags, 0);
    @(negedge clk);
    bank_load = 1'b0;
    rst = 1'b0;

    issue(ldi(1, 9'd5));
    chk("ldi5", last_wdata, 16'h0005);
    issue(ldi(1, 9'h1FF));
    chk("ldi_sext", last_wdata, 16'hFFFF);
    issue(ldi(1, 9'd5));
    issue(ldi(2, 9'd3));
    issue(mk(1, 3, 1, 2));
    chk("add_val", last_wdata, 16'h0008);
    chk("add_flags", flags, 3'b000);
    issue(mk(2, 4, 2, 1));
    chk("sub_val", last_wdata, 16'hFFFE);
    chk("sub_flags", flags, FL ? 3'b110 : 3'b000);
    issue(mk(7, 0, 1, 1));
    chk("cmp_we", last_we, 0);
    chk("cmp_flags", flags, FL ? 3'b001 : 3'b000);
    issue(mk(3, 5, 4, 1));
    issue(mk(4, 6, 4, 2));
    issue(mk(5, 7, 3, 0));
    issue(mk(1, 3, 3, 3));

    // instr_valid held high: one acceptance per idle cycle only
    ins = mk(1, 6, 1, 2);
    model(ins, ref_flags, lat, we, res, fnew, ra, rb);
    instr = ins;
    instr_valid = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (c > 0) @(negedge clk);
      chk("hold_ready", instr_ready, (c % 5) == 0);
      chk("hold_done", done, (c % 5) == 4);
      if ((c % 5) == 4) chk("hold_wdata", rf_wdata, res);
    end
    @(negedge clk);
    instr_valid = 1'b0;
    chk("hold_idle", instr_ready, 1);
    ref_rf[6] = res;
    ref_flags = fnew;

    // reset while an ADD sits in RD_B
    issue(mk(2, 4, 2, 1));
    instr = mk(1, 5, 1, 2);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("abort_rsel_b", rf_rsel, 3'd2);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_ready", instr_ready, 1);
    chk("abort_flags", flags, 0);
    chk("abort_we", rf_we, 0);
    ref_flags = '0;
    @(negedge clk);
    chk("abort_we_hold", rf_we, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle", busy, 0);

    for (int n = 0; n < 60; n++) issue(16'($urandom));

    @(negedge clk);
    for (int i = 0; i < 8; i++)
      chk($sformatf("bank_r%0d", i), bank[i], ref_rf[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
